// File: rtl/snake_pkg.sv
// Shared definitions for the snake display path.
//   obj_code_t      : cell object encoding produced by frame_tracker
//   COLOUR_*        : RGB565 fill colour per object
//   CMD_*           : LCD controller opcodes used for window setup and RAM write
//   painter_state_t : cell_painter sequencer states
//   colour_lut()    : object code -> RGB565 fill colour (undefined codes -> background)
`timescale 1ns/1ps
package snake_pkg;

   typedef enum logic [2:0] {
      OBJ_EMPTY  = 3'd0,
      OBJ_HEAD   = 3'd1,
      OBJ_BODY   = 3'd2,
      OBJ_APPLE  = 3'd3,
      OBJ_BORDER = 3'd4
   } obj_code_t;

   localparam logic [15:0] COLOUR_BG     = 16'h0000;
   localparam logic [15:0] COLOUR_HEAD   = 16'h07E0;
   localparam logic [15:0] COLOUR_BODY   = 16'h03E0;
   localparam logic [15:0] COLOUR_APPLE  = 16'hF800;
   localparam logic [15:0] COLOUR_BORDER = 16'hFFFF;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HDR  = 2'd2,
      PIX  = 2'd3
   } painter_state_t;

   function automatic logic [15:0] colour_lut(input logic [2:0] code);
      logic [15:0] colour;
      case (obj_code_t'(code))
         OBJ_HEAD:   colour = COLOUR_HEAD;
         OBJ_BODY:   colour = COLOUR_BODY;
         OBJ_APPLE:  colour = COLOUR_APPLE;
         OBJ_BORDER: colour = COLOUR_BORDER;
         default:    colour = COLOUR_BG;
      endcase
      return colour;
   endfunction

endpackage

// File: rtl/cell_fifo.sv
// Synchronous FIFO holding queued cells.
//   clk, nrst : clock, asynchronous active-low reset
//   push, din : write request and data (ignored when full unless a pop happens the same edge)
//   pop       : read request (ignored when empty); dout always shows the head entry
//   full, empty, count : occupancy status
`timescale 1ns/1ps
module cell_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cell_painter.sv
// Queues changed cells from frame_tracker and redraws each as a CELL_W x CELL_H block
// on the LCD bus: CASET xs,xe / PASET ys,ye / RAMWR followed by CELL_W*CELL_H colour words.
//   clk, nrst                  : clock, asynchronous active-low reset
//   enable, x, y, obj_code, diff : cell stream; a cell is queued when enable & diff
//   wr_valid, wr_ready         : bus word handshake (word taken when both high at posedge)
//   wr_dc, wr_data             : 0 = command (opcode in low byte), 1 = data word
//   busy                       : cells queued or a redraw in progress
//   overflow                   : sticky, a changed cell was dropped on a full queue
`timescale 1ns/1ps
module cell_painter
   import snake_pkg::*;
#(
   parameter int unsigned CELL_W     = 20,
   parameter int unsigned CELL_H     = 20,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        enable,
   input  logic [3:0]  x,
   input  logic [3:0]  y,
   input  logic [2:0]  obj_code,
   input  logic        diff,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic        wr_dc,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned NPIX = CELL_W * CELL_H;
   localparam int unsigned PCW  = $clog2(NPIX + 1);

   painter_state_t state, state_next;

   logic                          push_req;
   logic                          fifo_pop;
   logic [10:0]                   fifo_dout;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   logic [3:0]  head_x;
   logic [3:0]  head_y;
   logic [2:0]  head_code;
   logic [15:0] head_xs;
   logic [15:0] head_ys;

   logic [15:0]    xs, xe, ys, ye, colour;
   logic [2:0]     step;
   logic [2:0]     step_inc;
   logic [PCW-1:0] pix_cnt;
   logic           accept;
   logic           last_step;
   logic           last_pix;
   logic           hdr_dc;
   logic [15:0]    hdr_data;

   assign push_req = enable && diff;

   cell_fifo #(
      .WIDTH (11),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push_req),
      .din   ({x, y, obj_code}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_x    = fifo_dout[10:7];
   assign head_y    = fifo_dout[6:3];
   assign head_code = fifo_dout[2:0];
   assign head_xs   = 16'(head_x) * 16'(CELL_W);
   assign head_ys   = 16'(head_y) * 16'(CELL_H);

   assign accept    = wr_valid && wr_ready;
   assign last_step = (step == 3'd6);
   assign last_pix  = (pix_cnt == PCW'(NPIX - 1));
   assign busy      = (fifo_count != '0) || (state != IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      case (state)
         IDLE: if (!fifo_empty) state_next = LOAD;
         LOAD: begin
            fifo_pop   = 1'b1;
            state_next = HDR;
         end
         HDR:  if (accept && last_step) state_next = PIX;
         PIX:  if (accept && last_pix) state_next = fifo_empty ? IDLE : LOAD;
         default: state_next = IDLE;
      endcase
   end

   // Header word that follows the current step once it is accepted.
   always_comb begin
      step_inc = step + 3'd1;
      hdr_dc   = 1'b0;
      hdr_data = {8'h00, CMD_CASET};
      case (step_inc)
         3'd1: begin hdr_dc = 1'b1; hdr_data = xs; end
         3'd2: begin hdr_dc = 1'b1; hdr_data = xe; end
         3'd3: begin hdr_dc = 1'b0; hdr_data = {8'h00, CMD_PASET}; end
         3'd4: begin hdr_dc = 1'b1; hdr_data = ys; end
         3'd5: begin hdr_dc = 1'b1; hdr_data = ye; end
         3'd6: begin hdr_dc = 1'b0; hdr_data = {8'h00, CMD_RAMWR}; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) overflow <= 1'b0;
      else if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
   end

   // When a cell ends with more queued, CASET is already presented during LOAD so
   // wr_valid stays high; if that word is taken in LOAD, xs comes straight from the
   // FIFO head because the coordinate registers are only being loaded on that edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_valid <= 1'b0;
         wr_dc    <= 1'b0;
         wr_data  <= '0;
         step     <= '0;
         pix_cnt  <= '0;
         xs       <= '0;
         xe       <= '0;
         ys       <= '0;
         ye       <= '0;
         colour   <= '0;
      end else begin
         case (state)
            LOAD: begin
               xs     <= head_xs;
               xe     <= head_xs + 16'(CELL_W - 1);
               ys     <= head_ys;
               ye     <= head_ys + 16'(CELL_H - 1);
               colour <= colour_lut(head_code);
               if (accept) begin
                  step     <= 3'd1;
                  wr_valid <= 1'b1;
                  wr_dc    <= 1'b1;
                  wr_data  <= head_xs;
               end else if (!wr_valid) begin
                  step     <= '0;
                  wr_valid <= 1'b1;
                  wr_dc    <= 1'b0;
                  wr_data  <= {8'h00, CMD_CASET};
               end
            end
            HDR: begin
               if (accept) begin
                  if (last_step) begin
                     pix_cnt <= '0;
                     wr_dc   <= 1'b1;
                     wr_data <= colour;
                  end else begin
                     step    <= step_inc;
                     wr_dc   <= hdr_dc;
                     wr_data <= hdr_data;
                  end
               end
            end
            PIX: begin
               if (accept) begin
                  if (last_pix) begin
                     step <= '0;
                     if (!fifo_empty) begin
                        wr_valid <= 1'b1;
                        wr_dc    <= 1'b0;
                        wr_data  <= {8'h00, CMD_CASET};
                     end else begin
                        wr_valid <= 1'b0;
                        wr_dc    <= 1'b0;
                        wr_data  <= '0;
                     end
                  end else begin
                     pix_cnt <= pix_cnt + PCW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
